// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with a 2-entry skid buffer and registered back-pressure.
// Define PIPE_STATS_EN to build the saturating stall/flush statistics counters.
module pipe_stage_skid #(
  parameter int CTRL_W = 16,
  parameter int DATA_W = 128,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t            state;
  logic              m_valid;
  logic [CTRL_W-1:0] m_ctrl;
  logic [DATA_W-1:0] m_data;
  logic              s_valid;
  logic [CTRL_W-1:0] s_ctrl;
  logic [DATA_W-1:0] s_data;

  logic accept;
  logic send;

  assign in_ready  = (state != TWO);
  assign accept    = in_valid & in_ready;
  assign send      = m_valid & out_ready;
  assign out_valid = m_valid;
  assign out_ctrl  = m_valid ? m_ctrl : '0;
  assign out_data  = m_data;
  assign occupancy = state;

  // Data fields are only cleared by reset; flush kills valid and ctrl so bubbles read as NOPs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= EMPTY;
      m_valid <= 1'b0;
      m_ctrl  <= '0;
      m_data  <= '0;
      s_valid <= 1'b0;
      s_ctrl  <= '0;
      s_data  <= '0;
    end else if (flush) begin
      state   <= EMPTY;
      m_valid <= 1'b0;
      m_ctrl  <= '0;
      s_valid <= 1'b0;
      s_ctrl  <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            m_valid <= 1'b1;
            m_ctrl  <= in_ctrl;
            m_data  <= in_data;
            state   <= ONE;
          end
        end
        ONE: begin
          if (accept && send) begin
            m_ctrl <= in_ctrl;
            m_data <= in_data;
          end else if (send) begin
            m_valid <= 1'b0;
            m_ctrl  <= '0;
            state   <= EMPTY;
          end else if (accept) begin
            s_valid <= 1'b1;
            s_ctrl  <= in_ctrl;
            s_data  <= in_data;
            state   <= TWO;
          end
        end
        TWO: begin
          if (send) begin
            m_ctrl  <= s_ctrl;
            m_data  <= s_data;
            s_valid <= 1'b0;
            s_ctrl  <= '0;
            state   <= ONE;
          end
        end
        default: begin
          state   <= EMPTY;
          m_valid <= 1'b0;
          m_ctrl  <= '0;
          s_valid <= 1'b0;
          s_ctrl  <= '0;
        end
      endcase
    end
  end

`ifdef PIPE_STATS_EN
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  // Both counters saturate at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (in_valid && !in_ready && (stall_q != {CNT_W{1'b1}}))
        stall_q <= stall_q + 1'b1;
      if (flush && (state != EMPTY) && (flush_q != {CNT_W{1'b1}}))
        flush_q <= flush_q + 1'b1;
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: per-cycle vector table plus a FIFO scoreboard.
// Counter expectations follow whether PIPE_STATS_EN is defined.
module tb_pipe_stage_skid;

  localparam int CTRL_W = 16;
  localparam int DATA_W = 128;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              clk_en = 1'b0;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  logic       sat_in_ready;
  logic       sat_out_valid;
  logic [3:0] sat_out_ctrl;
  logic [7:0] sat_out_data;
  logic [1:0] sat_occupancy;
  logic [1:0] sat_stall_cnt;
  logic [1:0] sat_flush_cnt;

  int n_compared   = 0;
  int n_mismatched = 0;

  typedef struct {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
  } entry_t;

  typedef struct {
    logic              iv;
    logic              ordy;
    logic              fl;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
    logic              ev;
    logic [CTRL_W-1:0] ec;
    logic [1:0]        eo;
    logic              er;
  } vec_t;

  entry_t sb[$];
  vec_t   vecs[$];

  pipe_stage_skid #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );

  // Narrow-counter instance kept permanently stalled to exercise saturation.
  pipe_stage_skid #(.CTRL_W(4), .DATA_W(8), .CNT_W(2)) dut_sat (
    .clk       (clk),
    .rst       (rst),
    .flush     (1'b0),
    .in_valid  (1'b1),
    .in_ready  (sat_in_ready),
    .in_ctrl   (4'h5),
    .in_data   (8'hAA),
    .out_valid (sat_out_valid),
    .out_ready (1'b0),
    .out_ctrl  (sat_out_ctrl),
    .out_data  (sat_out_data),
    .occupancy (sat_occupancy),
    .stall_cnt (sat_stall_cnt),
    .flush_cnt (sat_flush_cnt)
  );

  initial begin
    forever begin
      #5;
      if (clk_en) clk = ~clk;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [DATA_W-1:0] actual,
                             input logic [DATA_W-1:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic addVec(input logic iv, input logic ordy, input logic fl,
                        input logic [CTRL_W-1:0] ctrl, input logic [DATA_W-1:0] data,
                        input logic ev, input logic [CTRL_W-1:0] ec,
                        input logic [1:0] eo, input logic er);
    vec_t v;
    v.iv = iv; v.ordy = ordy; v.fl = fl; v.ctrl = ctrl; v.data = data;
    v.ev = ev; v.ec = ec; v.eo = eo; v.er = er;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    in_valid  = v.iv;
    out_ready = v.ordy;
    flush     = v.fl;
    in_ctrl   = v.ctrl;
    in_data   = v.data;
    tick();
    checkOutput($sformatf("vec%0d_out_valid", idx), out_valid, v.ev);
    checkOutput($sformatf("vec%0d_out_ctrl", idx), out_ctrl, v.ec);
    checkOutput($sformatf("vec%0d_occupancy", idx), occupancy, v.eo);
    checkOutput($sformatf("vec%0d_in_ready", idx), in_ready, v.er);
  endtask

  task automatic pulseReset();
    #1 rst = 1'b1;
    #1;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_ctrl", out_ctrl, 0);
    checkOutput("rst_out_data", out_data, 0);
    checkOutput("rst_occupancy", occupancy, 0);
    checkOutput("rst_in_ready", in_ready, 1);
    rst = 1'b0;
    sb.delete();
  endtask

  // Reference FIFO: record accepted entries, compare each one the DUT hands downstream.
  always @(negedge clk) begin
    entry_t e;
    if (!rst) begin
      if (out_valid !== 1'b1) checkOutput("bubble_ctrl", out_ctrl, 0);
      if (flush) begin
        sb.delete();
      end else begin
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL sb_unexpected: got ctrl %0h data %0h, expected no output",
                     out_ctrl, out_data);
          end else begin
            e = sb.pop_front();
            checkOutput("sb_ctrl", out_ctrl, e.ctrl);
            checkOutput("sb_data", out_data, e.data);
          end
        end
        if (in_valid && in_ready) begin
          e.ctrl = in_ctrl;
          e.data = in_data;
          sb.push_back(e);
        end
      end
    end
  end

  initial begin
    logic [CNT_W-1:0] exp_stall;
    logic [CNT_W-1:0] exp_flush;
    logic [1:0]       exp_sat;

    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_ctrl = '0; in_data = '0;

    // Reset with the clock stopped must take effect immediately.
    #2 rst = 1'b1;
    #1;
    checkOutput("init_out_valid", out_valid, 0);
    checkOutput("init_out_ctrl", out_ctrl, 0);
    checkOutput("init_out_data", out_data, 0);
    checkOutput("init_occupancy", occupancy, 0);
    checkOutput("init_in_ready", in_ready, 1);
    checkOutput("init_stall_cnt", stall_cnt, 0);
    checkOutput("init_flush_cnt", flush_cnt, 0);
    #1 rst = 1'b0;
    clk_en = 1'b1;
    tick();

    for (int i = 0; i < 8; i++)
      addVec(1, 1, 0, CTRL_W'(i + 1), DATA_W'(32'h100 + i), 1, CTRL_W'(i + 1), 2'd1, 1);
    addVec(0, 1, 0, '0, '0, 0, 16'h0, 2'd0, 1);
    addVec(1, 0, 0, 16'h0A, 128'hA, 1, 16'h0A, 2'd1, 1);
    addVec(1, 0, 0, 16'h0B, 128'hB, 1, 16'h0A, 2'd2, 0);
    addVec(1, 0, 0, 16'h0C, 128'hC, 1, 16'h0A, 2'd2, 0);
    addVec(1, 1, 0, 16'h0C, 128'hC, 1, 16'h0B, 2'd1, 1);
    addVec(1, 1, 0, 16'h0C, 128'hC, 1, 16'h0C, 2'd1, 1);
    addVec(0, 1, 0, '0, '0, 0, 16'h0, 2'd0, 1);
    addVec(1, 0, 0, 16'h11, 128'h11, 1, 16'h11, 2'd1, 1);
    addVec(1, 0, 0, 16'h12, 128'h12, 1, 16'h11, 2'd2, 0);
    addVec(1, 1, 1, 16'h13, 128'h13, 0, 16'h0, 2'd0, 1);
    addVec(0, 1, 0, '0, '0, 0, 16'h0, 2'd0, 1);
    addVec(1, 1, 0, 16'h21, 128'h21, 1, 16'h21, 2'd1, 1);
    addVec(1, 1, 1, 16'h22, 128'h22, 0, 16'h0, 2'd0, 1);
    addVec(0, 1, 0, '0, '0, 0, 16'h0, 2'd0, 1);

    foreach (vecs[i]) applyStimulus(vecs[i], i);

    // Async reset while two entries are held, then a clean single push.
    in_valid = 1'b1; out_ready = 1'b0; flush = 1'b0;
    in_ctrl = 16'h31; in_data = 128'h131;
    tick();
    in_ctrl = 16'h32; in_data = 128'h132;
    tick();
    checkOutput("two_occupancy", occupancy, 2);
    in_valid = 1'b0;
    pulseReset();
    in_valid = 1'b1; out_ready = 1'b1;
    in_ctrl = 16'h41; in_data = 128'h141;
    tick();
    checkOutput("post_rst_valid", out_valid, 1);
    checkOutput("post_rst_ctrl", out_ctrl, 16'h41);
    checkOutput("post_rst_data", out_data, 128'h141);
    in_valid = 1'b0;
    tick();
    checkOutput("post_rst_empty", out_valid, 0);

    // Statistics: 5 stall cycles, two non-empty flushes, one empty flush.
    pulseReset();
    in_valid = 1'b1; out_ready = 1'b0; in_ctrl = 16'h51; in_data = 128'h151;
    tick();
    in_ctrl = 16'h52; in_data = 128'h152;
    tick();
    in_ctrl = 16'h53; in_data = 128'h153;
    for (int i = 0; i < 5; i++) tick();
    in_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b1; in_ctrl = 16'h54; in_data = 128'h154;
    tick();
    in_valid = 1'b0; flush = 1'b1;
    tick();
    tick();
    flush = 1'b0;
    tick();
`ifdef PIPE_STATS_EN
    exp_stall = CNT_W'(5);
    exp_flush = CNT_W'(2);
    exp_sat   = 2'd3;
`else
    exp_stall = '0;
    exp_flush = '0;
    exp_sat   = 2'd0;
`endif
    checkOutput("stall_cnt", stall_cnt, exp_stall);
    checkOutput("flush_cnt", flush_cnt, exp_flush);
    checkOutput("sat_stall_cnt", sat_stall_cnt, exp_sat);
    checkOutput("sat_flush_cnt", sat_flush_cnt, 0);
    checkOutput("sat_occupancy", sat_occupancy, 2);

    // Drain and confirm nothing accepted was lost.
    in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    checkOutput("drain_sb_empty", sb.size(), 0);
    checkOutput("drain_occupancy", occupancy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised pipeline stage register that replaces the fixed per-stage register layers (e.g. decode-to-execute).
- Carries a zero-on-bubble control field and a raw data field.
- Uses a valid/ready handshake with a 2-entry skid buffer, so stall back-pressure is registered and never combinationally chained across stages.
- Flush turns all held entries into bubbles; invalid outputs always present control = 0, i.e. a NOP.

Parameters:
- CTRL_W, 16: width of control field (RegWrite, MemWrite, Jump, Branch, ALUSrc, ResultSrc, ALUControl, ...); forced to 0 on bubble/flush/reset.
- DATA_W, 128: width of data field (PC, imm, PC+4, operands, register addresses); cleared to 0 on reset only.
- CNT_W, 16: width of optional statistics counters.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: asynchronous, active-high reset.
- flush, input, 1: synchronous; kill all held entries at next edge.
- in_valid, input, 1: upstream entry valid.
- in_ready, output, 1: stage can accept; registered (depends only on state).
- in_ctrl, input, CTRL_W: upstream control field.
- in_data, input, DATA_W: upstream data field.
- out_valid, output, 1: downstream entry valid.
- out_ready, input, 1: downstream accepts.
- out_ctrl, output, CTRL_W: control field; 0 whenever out_valid = 0.
- out_data, output, DATA_W: data field; don't-care when out_valid = 0, but holds its last value.
- occupancy, output, 2: number of held entries (0..2).
- stall_cnt, output, CNT_W: optional (PIPE_STATS_EN).
- flush_cnt, output, CNT_W: optional (PIPE_STATS_EN).

Behaviour:
- Storage: main register M (drives outputs) and skid register S, each holding {valid, ctrl, data}.
- State machine, encoded by occupancy: EMPTY (0), ONE (1, M valid), TWO (2, M and S valid).
- Handshakes: accept = in_valid & in_ready; send = out_valid & out_ready.
- in_ready = (state != TWO).
- out_valid = M.valid.
- out_ctrl = M.valid ? M.ctrl : 0.
- out_data = M.data.
- Transitions, when flush = 0:
  - EMPTY & accept -> ONE; M <= in.
  - ONE & accept & send -> ONE; M <= in (one per cycle, zero bubbles).
  - ONE & send & !accept -> EMPTY.
  - ONE & accept & !send -> TWO; S <= in; M holds.
  - TWO & send -> ONE; M <= S. No accept is possible because in_ready = 0.
  - All other combinations hold.
- Ordering: strictly FIFO; an entry is never dropped or duplicated.
- Latency: one cycle from accept to out_valid when EMPTY or ONE-with-send.
- Flush:
  - At the next edge, M.valid and S.valid are cleared, M.ctrl and S.ctrl are cleared, and state becomes EMPTY.
  - Flush has priority over accept and send in the same cycle; the incoming entry is discarded.
  - in_ready rises on the cycle after the flush.
- Reset:
  - Asynchronous; all registers are cleared immediately, regardless of clk.
  - Outputs under reset: out_valid = 0, out_ctrl = 0, out_data = 0, occupancy = 0, in_ready = 1, counters = 0.
  - Reset mid-transfer discards both entries.
- Data-only path: data fields are not cleared on flush, to save resets on wide data; downstream must qualify data with out_valid.
- All widths are as parameterised; no arithmetic apart from the optional counters.

Optional Feature:
- Macro: PIPE_STATS_EN.
- Defined:
  - stall_cnt increments each cycle with in_valid & !in_ready.
  - flush_cnt increments each cycle with flush & occupancy != 0.
  - Both saturate at all-ones; there is no wrap.
  - Both are cleared by rst only.
- Undefined: stall_cnt and flush_cnt ports are driven constant 0, and no counter flops are synthesised.

Test Plan:
- Reset values: assert rst mid-cycle with clk stopped -> out_valid = 0, out_ctrl = 0, out_data = 0, occupancy = 0, in_ready = 1 immediately.
- Streaming: out_ready = 1; push 8 entries, ctrl = i+1 and data = 0x100+i, one per cycle -> out_valid on each cycle from cycle 1; data 0x100..0x107 in order; occupancy stays 1.
- Back-pressure:
  - Push entries A, B, C with out_ready = 0 -> A held in M, B in S, occupancy = 2, in_ready = 0 after the edge that captured B; C is not accepted.
  - Release out_ready -> outputs A, B, C in order, no loss.
- Flush while occupancy = 2 with in_valid = 1 in the same cycle:
  - Next cycle: out_valid = 0, out_ctrl = 0, occupancy = 0, in_ready = 1.
  - The incoming entry never appears at the output.
- Async reset during TWO state: rst pulse between edges -> both entries vanish; first post-reset push appears after 1 cycle with the correct data.
- Counters (PIPE_STATS_EN defined):
  - 5 stall cycles plus 2 non-empty flushes -> stall_cnt = 5, flush_cnt = 2.
  - With CNT_W = 2, 6 stalls -> stall_cnt = 3 (saturated).
